// File: rtl/memory_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : memory_bus_responder
// Brief    : Target side of the as_n / wr_n / ack_n memory handshake. Latches
//            a request, inserts WAIT_CYCLES wait states, accesses an internal
//            register array, then holds ack_n low until as_n is withdrawn.
// Revision : 1.0 - initial release
// ============================================================================
module memory_bus_responder #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              as_n,
    input  logic              wr_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ack_n,
    output logic [1:0]        sm_state,
    output logic              busy,
    output logic              aborted
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_WAIT    = 2'b01,
        ST_ACK     = 2'b10,
        ST_RECOVER = 2'b11
    } state_t;

    localparam int         c_depth     = 1 << ADDR_W;
    localparam logic [3:0] c_wait_load = 4'(WAIT_CYCLES);

    state_t              r_state;
    state_t              w_next_state;
    logic [3:0]          r_wait_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_wr_n;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_ack_n;
    logic                r_aborted;
    logic [DATA_W-1:0]   r_mem [c_depth];

    logic                w_capture;
    logic                w_abort;
    logic                w_access;

    // State register; reset overrides every state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and per-cycle control strobes; abort is checked before the counter
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_abort      = 1'b0;
        w_access     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!as_n) begin
                    w_capture    = 1'b1;
                    w_next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (as_n) begin
                    w_abort      = 1'b1;
                    w_next_state = ST_IDLE;
                end else if (r_wait_cnt == 4'd0) begin
                    w_access     = 1'b1;
                    w_next_state = ST_ACK;
                end
            end
            ST_ACK: begin
                if (as_n) begin
                    w_next_state = ST_RECOVER;
                end
            end
            ST_RECOVER: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Request capture, wait counter, registered handshake outputs and read data
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt <= 4'd0;
            r_addr     <= '0;
            r_wr_n     <= 1'b1;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_ack_n    <= 1'b1;
            r_aborted  <= 1'b0;
        end else begin
            if (w_capture) begin
                r_addr     <= addr;
                r_wr_n     <= wr_n;
                r_wdata    <= wdata;
                r_wait_cnt <= c_wait_load;
            end else if (r_state == ST_WAIT && !as_n && r_wait_cnt != 4'd0) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end
            if (w_access && r_wr_n) begin
                r_rdata <= r_mem[r_addr];
            end
            // ack_n is low exactly while the FSM sits in ACK
            r_ack_n   <= (w_next_state != ST_ACK);
            r_aborted <= w_abort;
        end
    end

    // Storage array; deliberately not cleared, and a reset edge suppresses the write
    always_ff @(posedge clk) begin
        if (!reset && w_access && !r_wr_n) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

    assign rdata    = r_rdata;
    assign ack_n    = r_ack_n;
    assign sm_state = r_state;
    assign busy     = (r_state == ST_WAIT) || (r_state == ST_ACK);
    assign aborted  = r_aborted;

endmodule
`default_nettype wire

// File: tb/tb_memory_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_bus_responder
// Brief    : Directed self-checking bench; dut_a uses 2 wait states, dut_b 0.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_bus_responder;

    logic       clk = 1'b0;
    logic       reset_a, as_n_a, wr_n_a, ack_n_a, busy_a, aborted_a;
    logic       reset_b, as_n_b, wr_n_b, ack_n_b, busy_b, aborted_b;
    logic [3:0] addr_a, addr_b;
    logic [7:0] wdata_a, wdata_b, rdata_a, rdata_b;
    logic [1:0] st_a, st_b;

    logic [7:0] mem_a [16];
    logic [7:0] mem_b [16];
    logic [7:0] sb_q [$];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    memory_bus_responder #(.ADDR_W(4), .DATA_W(8), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .reset(reset_a), .as_n(as_n_a), .wr_n(wr_n_a), .addr(addr_a),
        .wdata(wdata_a), .rdata(rdata_a), .ack_n(ack_n_a), .sm_state(st_a),
        .busy(busy_a), .aborted(aborted_a)
    );

    memory_bus_responder #(.ADDR_W(4), .DATA_W(8), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .reset(reset_b), .as_n(as_n_b), .wr_n(wr_n_b), .addr(addr_b),
        .wdata(wdata_b), .rdata(rdata_b), .ack_n(ack_n_b), .sm_state(st_b),
        .busy(busy_b), .aborted(aborted_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_ack(input bit s);
        return s ? ack_n_b : ack_n_a;
    endfunction

    function automatic logic [7:0] get_rdata(input bit s);
        return s ? rdata_b : rdata_a;
    endfunction

    function automatic logic [1:0] get_st(input bit s);
        return s ? st_b : st_a;
    endfunction

    function automatic logic get_busy(input bit s);
        return s ? busy_b : busy_a;
    endfunction

    task automatic drive(input bit s, input logic as, input logic wr, input logic [3:0] ad,
                         input logic [7:0] wd);
        if (s) begin
            as_n_b = as; wr_n_b = wr; addr_b = ad; wdata_b = wd;
        end else begin
            as_n_a = as; wr_n_a = wr; addr_a = ad; wdata_a = wd;
        end
    endtask

    // One full handshake. wr=0 write, wr=1 read. chg scrambles addr/wdata after sampling.
    task automatic access(input bit s, input logic wr, input logic [3:0] ad, input logic [7:0] wd,
                          input int exp_lat, input int hold, input bit chg);
        int k;
        logic [7:0] exp;
        if (!wr) begin
            if (s) mem_b[ad] = wd; else mem_a[ad] = wd;
        end else begin
            sb_q.push_back(s ? mem_b[ad] : mem_a[ad]);
        end
        drive(s, 1'b0, wr, ad, wd);
        @(posedge clk); #1;
        if (chg) drive(s, 1'b0, wr, 4'd7, 8'h00);
        k = 0;
        while (get_ack(s) !== 1'b0 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("ack_latency", k, exp_lat);
        check("busy_at_ack", get_busy(s), 1'b1);
        if (wr) begin
            exp = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
            check("rdata_at_ack", get_rdata(s), exp);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("ack_held", get_ack(s), 1'b0);
        end
        drive(s, 1'b1, 1'b1, ad, wd);
        @(posedge clk); #1;
        check("ack_release", get_ack(s), 1'b1);
        check("state_recover", get_st(s), 2'b11);
        @(posedge clk); #1;
        check("state_idle", get_st(s), 2'b00);
        check("busy_idle", get_busy(s), 1'b0);
    endtask

    initial begin
        reset_a = 1'b1; reset_b = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 4'd0, 8'h00);
        drive(1'b1, 1'b1, 1'b1, 4'd0, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        reset_a = 1'b0; reset_b = 1'b0;

        // Reset values
        check("rst_state", st_a, 2'b00);
        check("rst_ack_n", ack_n_a, 1'b1);
        check("rst_rdata", rdata_a, 8'h00);
        check("rst_busy", busy_a, 1'b0);
        check("rst_aborted", aborted_a, 1'b0);
        check("rst_rdata_b", rdata_b, 8'h00);

        // Write then read, two wait states
        access(1'b0, 1'b0, 4'd3, 8'hA5, 3, 0, 1'b0);
        access(1'b0, 1'b1, 4'd3, 8'h00, 3, 0, 1'b0);

        // Zero wait states, top address
        access(1'b1, 1'b0, 4'd15, 8'h3C, 1, 0, 1'b0);
        access(1'b1, 1'b1, 4'd15, 8'h00, 1, 0, 1'b0);

        // Abort in the second WAIT cycle; prior contents must survive
        access(1'b0, 1'b0, 4'd1, 8'h11, 3, 0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 4'd1, 8'hFF);
        @(posedge clk); #1;
        check("abort_busy", busy_a, 1'b1);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b1, 4'd1, 8'hFF);
        @(posedge clk); #1;
        check("abort_pulse", aborted_a, 1'b1);
        check("abort_ack_n", ack_n_a, 1'b1);
        check("abort_state", st_a, 2'b00);
        @(posedge clk); #1;
        check("abort_pulse_end", aborted_a, 1'b0);
        check("abort_ack_n2", ack_n_a, 1'b1);
        access(1'b0, 1'b1, 4'd1, 8'h00, 3, 0, 1'b0);

        // Extended ACK: as_n held low five cycles after ack
        access(1'b0, 1'b1, 4'd3, 8'h00, 3, 5, 1'b0);

        // Inputs change after sampling
        access(1'b0, 1'b0, 4'd7, 8'h42, 3, 0, 1'b0);
        access(1'b0, 1'b0, 4'd2, 8'h5A, 3, 0, 1'b1);
        access(1'b0, 1'b1, 4'd2, 8'h00, 3, 0, 1'b0);
        access(1'b0, 1'b1, 4'd7, 8'h00, 3, 0, 1'b0);

        // Reset while in ACK; the write was already committed at ack
        drive(1'b0, 1'b0, 1'b0, 4'd9, 8'h77);
        mem_a[9] = 8'h77;
        repeat (4) @(posedge clk);
        #1;
        check("pre_rst_ack_state", st_a, 2'b10);
        reset_a = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 4'd9, 8'h77);
        @(posedge clk); #1;
        check("rst_ack_ack_n", ack_n_a, 1'b1);
        check("rst_ack_state", st_a, 2'b00);
        check("rst_ack_busy", busy_a, 1'b0);
        reset_a = 1'b0;

        // Reset while in WAIT; the write must be dropped
        drive(1'b0, 1'b0, 1'b0, 4'd9, 8'h88);
        @(posedge clk); #1;
        check("pre_rst_wait_state", st_a, 2'b01);
        reset_a = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 4'd9, 8'h88);
        @(posedge clk); #1;
        check("rst_wait_ack_n", ack_n_a, 1'b1);
        check("rst_wait_state", st_a, 2'b00);
        check("rst_wait_busy", busy_a, 1'b0);
        check("rst_wait_aborted", aborted_a, 1'b0);
        reset_a = 1'b0;
        @(posedge clk); #1;
        access(1'b0, 1'b1, 4'd9, 8'h00, 3, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
